// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter: round-robin two-port arbiter/sequencer in front of `mem`,     |
// | with a local range check and a done watchdog.                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [DATA_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [DATA_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_done,
  input  logic              mem_wr_done
);

  localparam int                BYTES    = DATA_W / 8;
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(DEPTH - BYTES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_cur_port;
  logic               r_last_grant;
  logic               r_we;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_win;
  logic               w_sel_we;
  logic [DATA_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_oor;
  logic               w_take;
  logic               w_done;
  logic               w_expired;

  // On a tie the port that did not win last time gets the grant.
  assign w_win       = (p0_req && p1_req) ? ~r_last_grant : p1_req;
  assign w_sel_we    = w_win ? p1_we    : p0_we;
  assign w_sel_addr  = w_win ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_win ? p1_wdata : p0_wdata;
  assign w_oor       = (w_sel_addr > MAX_ADDR);
  assign w_done      = r_we ? mem_wr_done : mem_rd_done;
  assign w_expired   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          w_take      = 1'b1;
          w_state_nxt = w_oor ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done || w_expired) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_port   <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      if (w_take) begin
        r_cur_port   <= w_win;
        r_last_grant <= w_win;
        r_we         <= w_sel_we;
        mem_addr     <= w_sel_addr;
        mem_wr_data  <= w_sel_wdata;
        r_err        <= w_oor;
      end
      case (r_state)
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A matching done wins over a watchdog expiry in the same cycle.
          if (w_done) begin
            r_err <= 1'b0;
            if (!r_we) begin
              if (r_cur_port) p1_rdata <= mem_rd_data;
              else            p0_rdata <= mem_rd_data;
            end
          end else if (w_expired) begin
            r_err <= 1'b1;
            if (!r_we) begin
              if (r_cur_port) p1_rdata <= '0;
              else            p0_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign p0_ack    = (r_state == S_RESP) && !r_cur_port;
  assign p1_ack    = (r_state == S_RESP) &&  r_cur_port;
  assign p0_err    = p0_ack && r_err;
  assign p1_err    = p1_ack && r_err;
  assign mem_rd_en = (r_state == S_ISSUE) && !r_we;
  assign mem_wr_en = (r_state == S_ISSUE) &&  r_we;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-array memory model, vector table,
// directed corner sequences and randomized accesses against a reference model.
`default_nettype none

module tb_mem_arbiter;

  localparam int DATA_W  = 64;
  localparam int DEPTH   = 1024;
  localparam int TIMEOUT = 16;
  localparam int BYTES   = DATA_W / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [63:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic        mem_rd_en, mem_wr_en, mem_rd_done, mem_wr_done;
  logic [63:0] mem_addr, mem_wr_data, mem_rd_data;

  mem_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory stand-in: one-cycle done; when muted it never answers.
  logic        mem_mute = 1'b0;
  logic        model_rd_done = 1'b0, model_wr_done = 1'b0;
  logic [63:0] model_rd_data = '0;
  logic        inj_rd = 1'b0;
  logic [63:0] inj_data = '0;
  logic [7:0]  mem_bytes [DEPTH] = '{default: 8'h00};

  always @(posedge clk) begin
    model_rd_done <= 1'b0;
    model_wr_done <= 1'b0;
    if (!mem_mute && mem_addr <= 64'(DEPTH - BYTES)) begin
      if (mem_rd_en) begin
        model_rd_done <= 1'b1;
        for (int i = 0; i < BYTES; i++)
          model_rd_data[8*i +: 8] <= mem_bytes[int'(mem_addr[9:0]) + i];
      end
      if (mem_wr_en) begin
        model_wr_done <= 1'b1;
        for (int i = 0; i < BYTES; i++)
          mem_bytes[int'(mem_addr[9:0]) + i] <= mem_wr_data[8*i +: 8];
      end
    end
  end

  assign mem_rd_done = model_rd_done | inj_rd;
  assign mem_wr_done = model_wr_done;
  assign mem_rd_data = inj_rd ? inj_data : model_rd_data;

  always @(negedge clk) begin
    if (!rst && p0_ack && p1_ack) begin
      fails++;
      $display("FAIL dual_ack: p0_ack=%b p1_ack=%b, required not both", p0_ack, p1_ack);
    end
    if (!rst && mem_rd_en && mem_wr_en) begin
      fails++;
      $display("FAIL dual_en: rd_en=%b wr_en=%b, required not both", mem_rd_en, mem_wr_en);
    end
  end

  // Reference memory contents, updated from the expected outcome only.
  logic [7:0] ref_bytes [DEPTH];

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < BYTES; i++) v[8*i +: 8] = ref_bytes[int'(a[9:0]) + i];
    return v;
  endfunction

  task automatic ref_wr(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < BYTES; i++) ref_bytes[int'(a[9:0]) + i] = d[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // Drives one request in an IDLE cycle and waits (bounded) for its ack.
  task automatic txn(input int port, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, output logic err, output logic [63:0] rdata,
                     output int lat, output int n_rd, output int n_wr);
    logic ackd;
    @(posedge clk); #1;
    drive(port, 1'b1, we, addr, wdata);
    lat = 0; n_rd = 0; n_wr = 0; ackd = 1'b0;
    while (!ackd && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (mem_rd_en) n_rd++;
      if (mem_wr_en) n_wr++;
      ackd = (port == 0) ? p0_ack : p1_ack;
    end
    err   = (port == 0) ? p0_err : p1_err;
    rdata = (port == 0) ? p0_rdata : p1_rdata;
    drive(port, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  task automatic run_vec(input string tag, input int port, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic exp_err, input int exp_lat,
                         input logic chk_rd, input logic [63:0] exp_rd);
    logic        err;
    logic [63:0] rdata;
    int          lat, n_rd, n_wr;
    logic        issued;
    txn(port, we, addr, wdata, err, rdata, lat, n_rd, n_wr);
    issued = (exp_lat != 1);
    check({tag, " err"}, 64'(err), 64'(exp_err));
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rd_en count"}, 64'(n_rd), 64'(issued && !we));
    check({tag, " wr_en count"}, 64'(n_wr), 64'(issued && we));
    if (chk_rd) check({tag, " rdata"}, rdata, exp_rd);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int nack;
    foreach (ref_bytes[i]) ref_bytes[i] = 8'h00;

    vecs[0]  = '{1, 1'b1, 64'h10,  64'h1122334455667788, 1'b0, 3, 64'h0};
    vecs[1]  = '{0, 1'b0, 64'h10,  64'h0, 1'b0, 3, 64'h1122334455667788};
    vecs[2]  = '{0, 1'b1, 64'd1016, 64'hA5A55A5A0F0FF0F0, 1'b0, 3, 64'h0};
    vecs[3]  = '{0, 1'b0, 64'd1016, 64'h0, 1'b0, 3, 64'hA5A55A5A0F0FF0F0};
    vecs[4]  = '{0, 1'b0, 64'd1017, 64'h0, 1'b1, 1, 64'h0};
    vecs[5]  = '{1, 1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h1, 1'b1, 1, 64'h0};
    vecs[6]  = '{0, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 1'b1, 1, 64'h0};
    vecs[7]  = '{1, 1'b0, 64'h10,  64'h0, 1'b0, 3, 64'h1122334455667788};
    vecs[8]  = '{1, 1'b1, 64'h13,  64'hDEADBEEFCAFEF00D, 1'b0, 3, 64'h0};
    vecs[9]  = '{0, 1'b0, 64'h10,  64'h0, 1'b0, 3, 64'hEFCAFEF00D667788};
    vecs[10] = '{1, 1'b0, 64'h18,  64'h0, 1'b0, 3, 64'h0000000000DEADBE};
    vecs[11] = '{0, 1'b0, 64'd1024, 64'h0, 1'b1, 1, 64'h0};

    // Reset state and quiet idle period.
    repeat (3) @(posedge clk);
    #1;
    check("reset p0_ack", 64'(p0_ack), 64'h0);
    check("reset p1_ack", 64'(p1_ack), 64'h0);
    check("reset rd_en", 64'(mem_rd_en), 64'h0);
    check("reset wr_en", 64'(mem_wr_en), 64'h0);
    check("reset mem_addr", mem_addr, 64'h0);
    check("reset mem_wr_data", mem_wr_data, 64'h0);
    check("reset p0_rdata", p0_rdata, 64'h0);
    check("reset p1_rdata", p1_rdata, 64'h0);
    @(negedge clk) rst = 1'b0;
    nack = 0;
    repeat (10) begin
      @(posedge clk); #1;
      nack += int'(mem_rd_en) + int'(mem_wr_en) + int'(p0_ack) + int'(p1_ack);
    end
    check("idle activity", 64'(nack), 64'h0);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_lat,
              !vecs[i].we && !vecs[i].exp_err, vecs[i].exp_rdata);
      if (vecs[i].we && !vecs[i].exp_err) ref_wr(vecs[i].addr, vecs[i].wdata);
    end

    // Randomized single-port accesses against the reference model.
    for (int i = 0; i < 60; i++) begin
      int          port, sel;
      logic        we, exp_err;
      logic [63:0] addr, wdata;
      port  = int'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      sel   = int'($urandom_range(0, 7));
      wdata = {$urandom, $urandom};
      if (sel == 0)      addr = {$urandom, $urandom};
      else if (sel == 1) addr = 64'(DEPTH - BYTES) + 64'($urandom_range(0, 10));
      else               addr = 64'($urandom_range(0, DEPTH - BYTES));
      exp_err = (addr > 64'(DEPTH - BYTES));
      run_vec($sformatf("rnd%0d", i), port, we, addr, wdata, exp_err,
              exp_err ? 1 : 3, !we && !exp_err, exp_err ? 64'h0 : ref_rd(addr));
      if (we && !exp_err) ref_wr(addr, wdata);
    end

    // Watchdog: memory never answers.
    mem_mute = 1'b1;
    run_vec("timeout rd", 0, 1'b0, 64'h10, 64'h0, 1'b1, 2 + TIMEOUT, 1'b1, 64'h0);
    run_vec("timeout wr", 1, 1'b1, 64'h40, 64'h0123456789ABCDEF, 1'b1, 2 + TIMEOUT, 1'b0, 64'h0);
    @(posedge clk); #1;
    inj_data = 64'h5555AAAA5555AAAA;
    inj_rd   = 1'b1;
    nack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      inj_rd = 1'b0;
      nack += int'(p0_ack) + int'(p1_ack);
    end
    check("late done ack", 64'(nack), 64'h0);
    check("late done rdata", p0_rdata, 64'h0);
    mem_mute = 1'b0;

    // Reset during WAIT aborts silently.
    run_vec("pre-reset rd", 0, 1'b0, 64'h10, 64'h0, 1'b0, 3, 1'b1, ref_rd(64'h10));
    mem_mute = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 64'h10, 64'h0);
    repeat (2) begin @(posedge clk); #1; end
    #3 rst = 1'b1;
    #1;
    check("midreset p0_ack", 64'(p0_ack), 64'h0);
    check("midreset mem_addr", mem_addr, 64'h0);
    check("midreset p0_rdata", p0_rdata, 64'h0);
    drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    inj_data = 64'h0BADF00D0BADF00D;
    inj_rd   = 1'b1;
    nack = 0;
    repeat (5) begin
      @(posedge clk); #1;
      inj_rd = 1'b0;
      nack += int'(p0_ack) + int'(p1_ack) + int'(mem_rd_en) + int'(mem_wr_en);
    end
    check("post-reset stale done", 64'(nack), 64'h0);
    check("post-reset p0_rdata", p0_rdata, 64'h0);
    mem_mute = 1'b0;

    // Round-robin with both ports requesting continuously after reset.
    begin
      int          got_port [4];
      int          got_cyc  [4];
      int          n, budget;
      logic [63:0] exp0, exp1;
      exp0 = ref_rd(64'h10);
      exp1 = ref_rd(64'h18);
      n = 0; budget = 0;
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 64'h10, 64'h0);
      drive(1, 1'b1, 1'b0, 64'h18, 64'h0);
      while (n < 4 && budget < 40) begin
        @(posedge clk); #1;
        budget++;
        if (p0_ack) begin
          got_port[n] = 0; got_cyc[n] = budget; n++;
          check("rr p0_rdata", p0_rdata, exp0);
        end else if (p1_ack) begin
          got_port[n] = 1; got_cyc[n] = budget; n++;
          check("rr p1_rdata", p1_rdata, exp1);
        end
      end
      drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
      drive(1, 1'b0, 1'b0, 64'h0, 64'h0);
      check("rr ack count", 64'(n), 64'd4);
      for (int i = 0; i < n; i++) begin
        check($sformatf("rr grant%0d port", i), 64'(got_port[i]), 64'(i % 2));
        check($sformatf("rr grant%0d cycle", i), 64'(got_cyc[i]), 64'(3 + 4 * i));
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port byte-addressed `mem` block. It shares the memory between port 0 (instruction fetch) and port 1 (load/store) with round-robin priority and issues one 64-bit access at a time. Each request gets exactly one `ack`, carrying read data and an error flag. Accesses that run past the end of memory are rejected locally, and accesses whose done pulse never arrives end on a watchdog timeout.

## Interface
- `DATA_W`, 64: data and address width; `BYTES = DATA_W/8`.
- `DEPTH`, 1024: memory size in bytes, must match the attached `mem`.
- `TIMEOUT`, 16: maximum WAIT cycles before a transaction is failed; must be ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pN_req`  in  1  request valid, N ∈ {0,1}; held with its fields until `pN_ack`.
- `pN_we`  in  1  1 = write, 0 = read.
- `pN_addr`  in  DATA_W  byte address of the lowest byte.
- `pN_wdata`  in  DATA_W  write data, little-endian bytes.
- `pN_ack`  out  1  one-cycle completion pulse.
- `pN_rdata`  out  DATA_W  read data; valid when `pN_ack`=1 and `pN_we`=0.
- `pN_err`  out  1  valid with `pN_ack`: out-of-range or timeout.
- `mem_rd_en`, `mem_wr_en`  out  1  one-cycle issue pulses to `mem`.
- `mem_addr`, `mem_wr_data`  out  DATA_W  registered access fields.
- `mem_rd_data`  in  DATA_W  read data from `mem`.
- `mem_rd_done`, `mem_wr_done`  in  1  completion pulses from `mem`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Sample both `req` lines and pick a winner: if only one requests, it wins; if both request, the port not in `last_grant` wins.
  - Latch `cur_port`, `we`, `addr` and `wdata`, and update `last_grant`.
  - Range check: if `addr > DEPTH-BYTES` (unsigned, full DATA_W compare), go to RESP with err=1 and pulse no mem enable.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Drive exactly one of `mem_rd_en` or `mem_wr_en` high for this cycle only, with `mem_addr`/`mem_wr_data` already valid.
  - Clear the watchdog counter and go to WAIT.
- **WAIT**
  - Increment the counter each cycle.
  - The matching done (`mem_rd_done` for a read, `mem_wr_done` for a write) goes to RESP with err=0. On a read, also capture `mem_rd_data` into the granted port's `rdata`.
  - If the counter reaches TIMEOUT without that done, go to RESP with err=1 and rdata=0.
  - A non-matching done is ignored.
- **RESP**
  - The granted port's `ack` is 1 for this cycle with its `err`; the other port's `ack`/`err` stay 0.
  - Always go to IDLE. Requests are not sampled in RESP.
- `mem_rd_done`/`mem_wr_done` arriving in IDLE, ISSUE or RESP are ignored (late or stale completions).
- `pN_rdata` holds its last captured value between acks. Writes leave `rdata` unchanged.

## Timing
- Reset (async assert, sync release): state=IDLE, `last_grant`=1 (port 0 wins the first tie). All `ack`/`err`/`mem_*_en` = 0; `mem_addr`, `mem_wr_data` and both `rdata` = 0; counter = 0.
- Reset mid-transaction aborts with no ack. A done pulse from `mem` that arrives after release is ignored, because state is IDLE.
- Normal access, with the request sampled at the end of cycle 0:
  - cycle 1: ISSUE, mem enable high.
  - cycle 2: `mem` done.
  - cycle 3: `ack`.
  - Latency is 3 cycles and throughput is one access per 4 cycles.
- Out-of-range access: `ack`+`err` in cycle 1, with no mem enable.
- Timeout access: `ack`+`err` in cycle 2+TIMEOUT.
- Handshake: the requester holds `req` and its fields stable until it sees `ack`. It may deassert or present a new request from the cycle after `ack`, when that request is sampled (IDLE).
- `ack` is never asserted to both ports in one cycle, and at most one mem transaction is outstanding.
- Both `mem_rd_en` and `mem_wr_en` are never high together.

## Test plan
- **Reset/idle:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately; no mem enable for 10 idle cycles.
- **Write then read:** p1 writes 0x1122334455667788 to addr 0x10 → `mem_wr_en` in cycle 1, `p1_ack` in cycle 3, err=0. p0 then reads 0x10 → `p0_ack` 3 cycles after its request with `p0_rdata`=0x1122334455667788.
- **Round-robin:** both ports request continuously from reset → grants alternate p0, p1, p0, p1, with acks 4 cycles apart and never simultaneous.
- **Range check:** p0 reads addr DEPTH-8=1016 → ok, err=0. p0 reads addr 1017 → `p0_ack`+`p0_err` in cycle 1 with no `mem_rd_en`. Address 0xFFFF_FFFF_FFFF_FFF8 → err, with no wrap-around acceptance.
- **Timeout:** replace `mem` with a model that never returns done, TIMEOUT=16 → `ack`+`err` at cycle 18 with rdata=0. A late done injected afterwards in IDLE is ignored.
- **Reset mid-op:** assert `rst` in WAIT → no ack; the subsequent `mem_rd_done` is ignored. The next request completes normally with p0 winning the first tie.
